// File: rtl/audio_framer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | audio_framer: circular PCM buffer cutting FRAME_LEN frames every HOP_SIZE. |
// | Option macro AUDIO_FRAMER_PREEMPH_EN adds write-path pre-emphasis. Rev 1.0 |
// +---------------------------------------------------------------------------+
module audio_framer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FRAME_LEN    = 306,
  parameter int HOP_SIZE     = 153,
  parameter int BUF_DEPTH    = 512,
  parameter int BUF_LOG2     = $clog2(BUF_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SAMPLE_WIDTH-1:0] sample_i,
  input  logic                    sample_valid_i,
  output logic                    start_o,
  input  logic                    rd_en_i,
  output logic                    valid_to_read_o,
  output logic [SAMPLE_WIDTH-1:0] frame_sample_o,
  input  logic                    done_i,
  output logic                    busy_o,
  output logic                    overflow_o,
  output logic [15:0]             frame_count_o
);

  localparam int CW = BUF_LOG2 + 1;
  localparam logic [CW-1:0] C_FRAME_LEN = CW'(FRAME_LEN);
  localparam logic [CW-1:0] C_HOP       = CW'(HOP_SIZE);
  localparam logic [CW-1:0] C_DEPTH     = CW'(BUF_DEPTH);

  typedef enum logic [1:0] {
    S_FILL      = 2'd0,
    S_ISSUE     = 2'd1,
    S_SERVE     = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [BUF_LOG2-1:0]     wr_ptr_q, wr_ptr_d;
  logic [BUF_LOG2-1:0]     base_ptr_q, base_ptr_d;
  logic [CW-1:0]           occ_q, occ_d;
  logic [CW-1:0]           rd_cnt_q, rd_cnt_d;
  logic                    valid_q, valid_d;
  logic                    overflow_q, overflow_d;
  logic [SAMPLE_WIDTH-1:0] frame_sample_q, frame_sample_d;
  logic [15:0]             frame_count_q, frame_count_d;

  logic [SAMPLE_WIDTH-1:0] mem [BUF_DEPTH];
  logic                    wr_accept;
  logic                    hop;
  logic                    rd_fire;
  logic [BUF_LOG2-1:0]     rd_addr;
  logic [SAMPLE_WIDTH-1:0] wr_data;

`ifdef AUDIO_FRAMER_PREEMPH_EN
  // y = sat(x - (x_prev*31 >>> 5)), evaluated with 6 bits of headroom.
  localparam int PW = SAMPLE_WIDTH + 6;
  localparam logic signed [PW-1:0] C_MAXV = {{7{1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] C_MINV = {{7{1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

  logic [SAMPLE_WIDTH-1:0] prev_q, prev_d;
  logic signed [PW-1:0]    prev_ext, x_ext, scaled, diff;

  always_comb begin
    prev_ext = {{6{prev_q[SAMPLE_WIDTH-1]}}, prev_q};
    x_ext    = {{6{sample_i[SAMPLE_WIDTH-1]}}, sample_i};
    scaled   = ((prev_ext <<< 5) - prev_ext) >>> 5;
    diff     = x_ext - scaled;
    if (diff > C_MAXV) begin
      wr_data = C_MAXV[SAMPLE_WIDTH-1:0];
    end else if (diff < C_MINV) begin
      wr_data = C_MINV[SAMPLE_WIDTH-1:0];
    end else begin
      wr_data = diff[SAMPLE_WIDTH-1:0];
    end
    prev_d = wr_accept ? sample_i : prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end
`else
  assign wr_data = sample_i;
`endif

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    base_ptr_d    = base_ptr_q;
    rd_cnt_d      = rd_cnt_q;
    overflow_d    = overflow_q;
    frame_count_d = frame_count_q;

    wr_accept = sample_valid_i && (occ_q != C_DEPTH);
    hop       = (state_q == S_WAIT_DONE) && done_i;
    rd_fire   = (state_q == S_SERVE) && rd_en_i && (rd_cnt_q < C_FRAME_LEN);
    rd_addr   = base_ptr_q + rd_cnt_q[BUF_LOG2-1:0];

    valid_d        = rd_fire;
    frame_sample_d = rd_fire ? mem[rd_addr] : frame_sample_q;

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + BUF_LOG2'(1);
    end
    if (sample_valid_i && !wr_accept) begin
      overflow_d = 1'b1;
    end
    // Write and hop release can land in the same cycle; both terms apply.
    occ_d = occ_q + CW'(wr_accept) - (hop ? C_HOP : '0);

    case (state_q)
      S_FILL: begin
        if (occ_q >= C_FRAME_LEN) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        rd_cnt_d      = '0;
        frame_count_d = frame_count_q + 16'd1;
        state_d       = S_SERVE;
      end
      S_SERVE: begin
        if (rd_fire) begin
          rd_cnt_d = rd_cnt_q + CW'(1);
        end
        // rd_cnt reaches FRAME_LEN in the same cycle the last valid is shown.
        if (rd_cnt_q == C_FRAME_LEN) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (done_i) begin
          base_ptr_d = base_ptr_q + BUF_LOG2'(HOP_SIZE);
          state_d    = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_FILL;
      wr_ptr_q       <= '0;
      base_ptr_q     <= '0;
      occ_q          <= '0;
      rd_cnt_q       <= '0;
      valid_q        <= 1'b0;
      overflow_q     <= 1'b0;
      frame_sample_q <= '0;
      frame_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      base_ptr_q     <= base_ptr_d;
      occ_q          <= occ_d;
      rd_cnt_q       <= rd_cnt_d;
      valid_q        <= valid_d;
      overflow_q     <= overflow_d;
      frame_sample_q <= frame_sample_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign start_o         = (state_q == S_ISSUE);
  assign busy_o          = (state_q == S_SERVE) || (state_q == S_WAIT_DONE);
  assign valid_to_read_o = valid_q;
  assign frame_sample_o  = frame_sample_q;
  assign overflow_o      = overflow_q;
  assign frame_count_o   = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_framer.sv
`default_nettype none
// tb_audio_framer: directed bench for audio_framer at default parameters,
// using a shadow buffer model to predict frame contents.
module tb_audio_framer;
  localparam int FRAME = 306;
  localparam int HOP   = 153;
  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sample_i = '0;
  logic        sample_valid_i = 1'b0;
  logic        start_o;
  logic        rd_en_i = 1'b0;
  logic        valid_to_read_o;
  logic [15:0] frame_sample_o;
  logic        done_i = 1'b0;
  logic        busy_o;
  logic        overflow_o;
  logic [15:0] frame_count_o;

  always #5 clk = ~clk;

  audio_framer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .start_o        (start_o),
    .rd_en_i        (rd_en_i),
    .valid_to_read_o(valid_to_read_o),
    .frame_sample_o (frame_sample_o),
    .done_i         (done_i),
    .busy_o         (busy_o),
    .overflow_o     (overflow_o),
    .frame_count_o  (frame_count_o)
  );

  int errors = 0;
  int checks = 0;
  int starts = 0;
  int exp_starts = 0;
  int exp_fc = 0;
  bit start_now = 1'b0;

  logic [15:0] m_mem [DEPTH];
  int          m_wr = 0;
  int          m_occ = 0;
  int          m_base = 0;
  logic [15:0] m_prev = '0;
  logic [15:0] last_data = '0;
  logic [15:0] rx [FRAME];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    start_now = start_o;
    if (start_o) starts++;
  endtask

  task automatic model_write(input logic [15:0] x);
    logic [15:0] v = x;
`ifdef AUDIO_FRAMER_PREEMPH_EN
    int d = int'($signed(x)) - ((int'($signed(m_prev)) * 31) >>> 5);
    if (d > 32767) d = 32767;
    else if (d < -32768) d = -32768;
    v = 16'(d);
`endif
    if (m_occ < DEPTH) begin
      m_mem[m_wr] = v;
      m_wr = (m_wr + 1) % DEPTH;
      m_occ++;
      m_prev = x;
    end
  endtask

  task automatic feed(input int n, input int v0);
    for (int i = 0; i < n; i++) begin
      sample_i = 16'(v0 + i);
      sample_valid_i = 1'b1;
      model_write(16'(v0 + i));
      tick();
    end
    sample_valid_i = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int t = 0;
    exp_starts++;
    exp_fc++;
    while (starts < exp_starts && t < 40) begin
      tick();
      t++;
    end
    if (start_now) tick();
    chk({tag, "_start"}, starts, exp_starts);
    chk({tag, "_busy"}, busy_o, 1);
    chk({tag, "_fcount"}, frame_count_o, 32'(16'(exp_fc)));
  endtask

  task automatic serve(input int count, input bit toggle, input string tag);
    int got = 0;
    bit req;
    logic [15:0] exp;
    for (int c = 0; c < 4 * FRAME && got < count; c++) begin
      rd_en_i = toggle ? (c % 2 == 0) : 1'b1;
      tick();
      req = rd_en_i && (got < FRAME);
      chk({tag, "_valid"}, valid_to_read_o, req);
      if (req) begin
        exp = m_mem[(m_base + got) % DEPTH];
        chk({tag, "_data"}, frame_sample_o, exp);
        rx[got] = frame_sample_o;
        last_data = exp;
        got++;
      end else begin
        chk({tag, "_hold"}, frame_sample_o, last_data);
      end
    end
    rd_en_i = 1'b0;
    chk({tag, "_count"}, got, count);
  endtask

  task automatic post_frame(input string tag);
    rd_en_i = 1'b1;
    tick();
    chk({tag, "_extra_rd_valid"}, valid_to_read_o, 0);
    chk({tag, "_extra_rd_hold"}, frame_sample_o, last_data);
    tick();
    rd_en_i = 1'b0;
    chk({tag, "_wait_busy"}, busy_o, 1);
    chk({tag, "_wait_nostart"}, start_o, 0);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    m_base = (m_base + HOP) % DEPTH;
    m_occ -= HOP;
    chk({tag, "_idle_busy"}, busy_o, 0);
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_start"}, start_o, 0);
    chk({tag, "_valid"}, valid_to_read_o, 0);
    chk({tag, "_data"}, frame_sample_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_ovf"}, overflow_o, 0);
    chk({tag, "_fcount"}, frame_count_o, 0);
    #2 rst_n = 1'b1;
    m_wr = 0; m_occ = 0; m_base = 0; m_prev = '0; last_data = '0; exp_fc = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    chk("rst_start", start_o, 0);
    chk("rst_valid", valid_to_read_o, 0);
    chk("rst_data", frame_sample_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_fcount", frame_count_o, 0);
    #5 rst_n = 1'b1;
    tick();

    // Frame 1: samples 1..306, continuous reads.
    feed(FRAME, 1);
    chk("f1_no_early_start", starts, 0);
    wait_start("f1");
    serve(FRAME, 1'b0, "f1");
`ifndef AUDIO_FRAMER_PREEMPH_EN
    chk("f1_first", rx[0], 1);
    chk("f1_last", rx[FRAME-1], 306);
`endif
    post_frame("f1");

    // Frame 2 after one hop, with rd_en toggling.
    feed(HOP, 307);
    wait_start("f2");
    serve(FRAME, 1'b1, "f2");
`ifndef AUDIO_FRAMER_PREEMPH_EN
    chk("f2_first", rx[0], 154);
    chk("f2_last", rx[FRAME-1], 459);
`endif
    post_frame("f2");

    // Reset in the middle of SERVE.
    feed(HOP, 460);
    wait_start("f3");
    serve(100, 1'b0, "f3");
    async_reset("midrst");
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    feed(FRAME - 1, 5000);
    chk("midrst_no_start_305", starts, exp_starts);
    feed(1, 5000 + FRAME - 1);
    wait_start("f4");
    serve(FRAME, 1'b0, "f4");
`ifndef AUDIO_FRAMER_PREEMPH_EN
    chk("f4_first", rx[0], 5000);
`endif
    post_frame("f4");

    // Overflow: 600 samples with no done.
    async_reset("rst2");
    feed(DEPTH, 1000);
    chk("ov_not_yet", overflow_o, 0);
    feed(600 - DEPTH, 1000 + DEPTH);
    chk("ov_set", overflow_o, 1);
    wait_start("ov1");
    serve(FRAME, 1'b0, "ov1");
    post_frame("ov1");
    wait_start("ov2");
    serve(FRAME, 1'b0, "ov2");
    post_frame("ov2");
    feed(100, 2000);
    wait_start("ov3");
    serve(FRAME, 1'b0, "ov3");
`ifndef AUDIO_FRAMER_PREEMPH_EN
    chk("ov3_last_accepted", rx[205], 1511);
    chk("ov3_after_wrap", rx[206], 2000);
`endif
    chk("ov_sticky", overflow_o, 1);
    post_frame("ov3");

`ifdef AUDIO_FRAMER_PREEMPH_EN
    async_reset("rst3");
    feed(1, 32767);
    feed(1, 32767);
    feed(1, -32768);
    feed(FRAME - 3, 0);
    wait_start("pe");
    serve(FRAME, 1'b0, "pe");
    chk("pe_s0", rx[0], 32'(16'h7fff));
    chk("pe_s1", rx[1], 32'(16'd1024));
    chk("pe_s2", rx[2], 32'(16'h8000));
    post_frame("pe");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
